// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-serial data memory with load/store FSM, sub-word access and alignment faults
module data_mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_enable,
  input  logic              mem_RW,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              mem_busy,
  output logic              align_fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, size_q, size_d;
  logic rw_q, rw_d, fault_q, fault_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] mem_q [2**ADDR_W];
  logic accept, misaligned;
  logic [1:0] last_idx;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0] rd_byte, wr_byte;
  assign accept     = mem_enable && state_q != ACCESS;
  assign misaligned = (mem_size == 2'b01) ? addr[0] : (mem_size == 2'b10) ? 1'b0 : |addr[1:0];
  assign last_idx   = (size_q == 2'b01) ? 2'd1 : (size_q == 2'b10) ? 2'd0 : 2'd3;
  assign byte_addr  = addr_q + ADDR_W'(cnt_q);
  assign rd_byte    = mem_q[byte_addr];
  assign wr_byte    = wdata_q[{cnt_q, 3'b000} +: 8];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    rw_d    = rw_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == ACCESS) begin
      // byte 0 of a load starts a fresh word so unused upper lanes read as zero
      rdata_d = rw_q ? rdata_q : ((cnt_q == 2'd0 ? 32'd0 : rdata_q) | (32'(rd_byte) << {cnt_q, 3'b000}));
      cnt_d   = cnt_q + 2'd1;
      state_d = (cnt_q == last_idx) ? RESP : ACCESS;
    end else if (accept) begin
      cnt_d   = '0;
      size_d  = mem_size;
      rw_d    = mem_RW;
      addr_d  = addr;
      wdata_d = wdata;
      fault_d = misaligned;
      rdata_d = misaligned ? 32'd0 : rdata_q;
      state_d = misaligned ? RESP : ACCESS;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // storage is deliberately outside the reset domain; reset forces IDLE, which blocks writes
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && rw_q) mem_q[byte_addr] <= wr_byte;
  end
  assign rdata       = rdata_q;
  assign mem_busy    = state_q == ACCESS;
  assign rdata_valid = state_q == RESP;
  assign align_fault = rdata_valid & fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized load/store traffic against a byte-array reference model
module tb_data_mem_responder;
  logic clk = 1'b0, reset_n = 1'b0, mem_enable = 1'b0, mem_RW = 1'b0;
  logic [1:0] mem_size = '0;
  logic [7:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic rdata_valid, mem_busy, align_fault;
  int checks = 0, failures = 0;
  logic [7:0] mdl [256];
  logic [31:0] exp_rd = '0;
  always #5 clk = ~clk;
  data_mem_responder #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .mem_enable(mem_enable), .mem_RW(mem_RW),
    .mem_size(mem_size), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .mem_busy(mem_busy), .align_fault(align_fault)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(rdata_valid), 0);
    check({tag, "_busy"}, 32'(mem_busy), 0);
    check({tag, "_fault"}, 32'(align_fault), 0);
  endtask
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    int n, c, busy;
    logic mis;
    logic [31:0] v;
    mis = (sz == 2'd1) ? a[0] : (sz == 2'd2) ? 1'b0 : (a[1:0] != 2'd0);
    n = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
    mem_RW = rw; mem_size = sz; addr = a; wdata = wd; mem_enable = 1'b1;
    step;
    c = 1; busy = 0;
    while (!rdata_valid && c < 20) begin
      busy += int'(mem_busy);
      mem_RW = 1'($urandom); mem_size = 2'($urandom); addr = 8'($urandom);
      wdata = $urandom; mem_enable = 1'($urandom);
      step;
      c++;
    end
    mem_enable = 1'b0;
    if (mis) exp_rd = 32'd0;
    else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) begin
        if (rw) mdl[8'(a + 8'(k))] = wd[8*k +: 8];
        else v |= 32'(mdl[8'(a + 8'(k))]) << (8*k);
      end
      if (!rw) exp_rd = v;
    end
    check("resp_valid", 32'(rdata_valid), 1);
    check("latency", 32'(c), mis ? 32'd1 : 32'(n + 1));
    check("busy_cycles", 32'(busy), mis ? 32'd0 : 32'(n));
    check("busy_in_resp", 32'(mem_busy), 0);
    check("align_fault", 32'(align_fault), 32'(mis));
    check("rdata", rdata, exp_rd);
  endtask
  initial begin
    #2;
    check("rst_rdata", rdata, 0);
    check_quiet("rst");
    step; step;
    reset_n = 1'b1;
    step;
    check_quiet("idle_after_rst");
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd0, 8'(i*4), $urandom);
    step;
    check_quiet("idle_after_init");
    do_req(1'b1, 2'd0, 8'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'd0, 8'h10, 32'h0);
    check("word_load_const", rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 8'h11, 32'h0);
    check("byte_load_const", rdata, 32'h000000BE);
    do_req(1'b0, 2'd1, 8'h12, 32'h0);
    check("half_load_const", rdata, 32'h0000DEAD);
    do_req(1'b1, 2'd2, 8'h13, 32'hFFFFFF55);
    check("store_keeps_rdata", rdata, 32'h0000DEAD);
    do_req(1'b0, 2'd0, 8'h10, 32'h0);
    check("merged_load_const", rdata, 32'h55ADBEEF);
    do_req(1'b0, 2'd0, 8'h12, 32'h0);
    do_req(1'b1, 2'd0, 8'h11, 32'hA5A5A5A5);
    do_req(1'b1, 2'd1, 8'h13, 32'h5A5A5A5A);
    do_req(1'b0, 2'd3, 8'h10, 32'h0);
    check("no_write_on_fault", rdata, 32'h55ADBEEF);
    step;
    check_quiet("idle_return");
    do_req(1'b1, 2'd0, 8'h20, 32'h0);
    step;
    mem_RW = 1'b1; mem_size = 2'd0; addr = 8'h20; wdata = 32'h11223344; mem_enable = 1'b1;
    step;
    mem_enable = 1'b0;
    step; step;
    reset_n = 1'b0;
    #1;
    mdl[8'h20] = 8'h44; mdl[8'h21] = 8'h33; exp_rd = 32'd0;
    check("midrst_rdata", rdata, 0);
    check_quiet("midrst");
    step; step;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check_quiet("post_rst");
    end
    do_req(1'b0, 2'd0, 8'h20, 32'h0);
    check("partial_store_const", rdata, 32'h00003344);
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), 2'($urandom), 8'($urandom), $urandom);
      if ($urandom_range(3) == 0) begin
        step;
        check_quiet("rand_idle");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, byte-address width; the memory SHALL hold 2**ADDR_W bytes.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port mem_enable, input, 1 bit: request strobe.
REQ-005 The block SHALL have port mem_RW, input, 1 bit: 1 = store (write), 0 = load (read).
REQ-006 The block SHALL have port mem_size, input, 2 bits: 00 word, 01 halfword, 10 byte, 11 word.
REQ-007 The block SHALL have port addr, input, ADDR_W bits: byte address.
REQ-008 The block SHALL have port wdata, input, 32 bits: store data, with the low bytes used for byte/halfword stores.
REQ-009 The block SHALL have port rdata, output, 32 bits: load result, zero-extended.
REQ-010 The block SHALL have port rdata_valid, output, 1 bit: one-cycle response pulse for both load and store.
REQ-011 The block SHALL have port mem_busy, output, 1 bit: pipeline stall, high while a transfer is in progress.
REQ-012 The block SHALL have port align_fault, output, 1 bit: one-cycle pulse, coincident with rdata_valid, for a misaligned request.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and RESP; mem_busy SHALL equal (state == ACCESS), and rdata_valid SHALL equal (state == RESP).
REQ-014 A request SHALL be accepted on a rising edge where mem_enable=1 and state is IDLE or RESP; mem_enable SHALL be ignored in ACCESS.
REQ-015 On acceptance, the block SHALL latch addr, mem_size, mem_RW and wdata, and SHALL clear the byte counter.
REQ-016 The transfer length N SHALL be 4 for a word, 2 for a halfword and 1 for a byte.
REQ-017 A request SHALL be misaligned if it is a halfword with addr[0]=1, or a word with addr[1:0]≠00.
REQ-018 An aligned request SHALL move to ACCESS, where it SHALL transfer exactly one byte per cycle at latched address + counter, little-endian (byte k ↔ data bits [8k+7:8k]).
REQ-019 After the Nth ACCESS cycle, the FSM SHALL enter RESP; total latency from the accepting edge to rdata_valid SHALL be N+1 cycles.
REQ-020 Store: each ACCESS cycle SHALL write wdata byte k to memory; rdata SHALL be unchanged by a store.
REQ-021 Load: each ACCESS cycle SHALL place the read byte into rdata lane k, with the upper unused lanes cleared to 0; rdata SHALL be stable from RESP until the next load response.
REQ-022 A misaligned request SHALL go directly to RESP with align_fault=1 and rdata=0, with no memory write.
REQ-023 In RESP without a new request, the FSM SHALL return to IDLE; with a new request, it SHALL follow REQ-014..REQ-022, giving back-to-back operation.
REQ-024 Input changes during ACCESS SHALL have no effect on the transfer in progress.

Reset
REQ-025 While reset_n=0, the block SHALL hold state=IDLE, counter=0, rdata=0, rdata_valid=0, mem_busy=0 and align_fault=0.
REQ-026 Memory array contents SHALL NOT be reset.
REQ-027 On a reset mid-transfer, bytes already written SHALL remain, the transfer SHALL be abandoned, and no response SHALL be produced.

Verification
REQ-028 Word store followed by load: store 0xDEADBEEF at addr 0x10, then load a word from 0x10 -> rdata=0xDEADBEEF, and mem_busy is high for 4 cycles on each operation.
REQ-029 Sub-word access: load a byte from 0x11 -> 0x000000BE; load a halfword from 0x12 -> 0x0000DEAD; byte store 0x55 to 0x13, then word load from 0x10 -> 0x55ADBEEF.
REQ-030 Misalignment: word load from 0x12 -> align_fault and rdata_valid pulse 1 cycle after acceptance, rdata=0, memory unchanged, and mem_busy never asserted.
REQ-031 Back-to-back: a new request held during RESP -> accepted with no IDLE cycle, and the second rdata_valid follows N+1 cycles later.
REQ-032 Reset mid-store: assert reset_n=0 after 2 ACCESS cycles of a word store of 0x11223344 to 0x20 (prior contents 0) -> outputs at reset values, no rdata_valid; a subsequent load from 0x20 -> 0x00003344.
